// File: rtl/trace_pkg.sv
// Shared types for the retirement trace unit: record kinds and the packed trace record.
package trace_pkg;

  localparam int TRACE_CNT_W = 32;

  typedef enum logic [2:0] {
    KIND_REG     = 3'd0,
    KIND_LOAD    = 3'd1,
    KIND_STORE   = 3'd2,
    KIND_NOP     = 3'd3,
    KIND_HALT    = 3'd4,
    KIND_TIMEOUT = 3'd5
  } rec_kind_t;

  typedef struct packed {
    rec_kind_t               kind;
    logic [TRACE_CNT_W-1:0]  inum;
    logic [15:0]             pc;
    logic [3:0]              dst_reg;
    logic [15:0]             value;
    logic [15:0]             addr;
  } trace_rec_t;

  function automatic logic is_terminal(input rec_kind_t kind);
    return (kind == KIND_HALT) || (kind == KIND_TIMEOUT);
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous DEPTH-entry FIFO of trace records; pointers carry an extra wrap bit.
module trace_fifo
  import trace_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  trace_rec_t din,
  output logic       full,
  output logic       empty,
  output trace_rec_t head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  trace_rec_t    mem [DEPTH];
  logic [AW:0]   wr_ptr_r;
  logic [AW:0]   rd_ptr_r;

  // Pointer advance; a push while full is only legal together with a pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
    end
  end

  // Record storage.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_r[AW-1:0]] <= din;
  end

  assign empty = (wr_ptr_r == rd_ptr_r);
  assign full  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                 (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign head  = mem[rd_ptr_r[AW-1:0]];

endmodule

// File: rtl/retire_trace_unit.sv
// Per-cycle retirement monitor: classifies each core cycle into a numbered trace record,
// buffers it in a FIFO and drains it over a valid/ready port.
module retire_trace_unit
  import trace_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int CNT_W    = 32,
  parameter int WATCHDOG = 100000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      pc,
  input  logic             reg_write,
  input  logic [3:0]       write_reg,
  input  logic [15:0]      write_data,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic [15:0]      mem_addr,
  input  logic [15:0]      mem_data,
  input  logic             halt,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic [2:0]       rec_kind,
  output logic [CNT_W-1:0] rec_inum,
  output logic [15:0]      rec_pc,
  output logic [3:0]       rec_reg,
  output logic [15:0]      rec_value,
  output logic [15:0]      rec_addr,
  output logic [CNT_W-1:0] inst_count,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] drop_count,
  output logic             overflow,
  output logic             done,
  output logic             timeout
);

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_TERM_PEND = 2'd1,
    ST_DONE      = 2'd2
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] inst_cnt_r, cycle_cnt_r, drop_cnt_r;
  logic [CNT_W-1:0] inst_inc_s, cycle_inc_s, drop_inc_s;
  logic             overflow_r, done_r, timeout_r;
  trace_rec_t       pend_r, cap_s, fifo_din_s, head_s;
  logic             full_s, empty_s, pop_s, push_s, space_s, wd_hit_s;

  assign inst_inc_s  = (&inst_cnt_r)  ? inst_cnt_r  : inst_cnt_r  + CNT_W'(1);
  assign cycle_inc_s = (&cycle_cnt_r) ? cycle_cnt_r : cycle_cnt_r + CNT_W'(1);
  assign drop_inc_s  = (&drop_cnt_r)  ? drop_cnt_r  : drop_cnt_r  + CNT_W'(1);

  // The watchdog fires on the edge at which cycle_count reaches WATCHDOG.
  assign wd_hit_s = (cycle_inc_s == CNT_W'(WATCHDOG));
  assign pop_s    = !empty_s && rec_ready;
  assign space_s  = !full_s || pop_s;

  // Classifier: priority halt > watchdog > load > reg write > store > nop.
  always_comb begin
    cap_s      = '0;
    cap_s.inum = TRACE_CNT_W'(inst_cnt_r);
    cap_s.pc   = pc;
    if (halt) begin
      cap_s.kind = KIND_HALT;
    end else if (wd_hit_s) begin
      cap_s.kind = KIND_TIMEOUT;
    end else if (reg_write && mem_read) begin
      cap_s.kind    = KIND_LOAD;
      cap_s.dst_reg = write_reg;
      cap_s.value   = write_data;
      cap_s.addr    = mem_addr;
    end else if (reg_write) begin
      cap_s.kind    = KIND_REG;
      cap_s.dst_reg = write_reg;
      cap_s.value   = write_data;
    end else if (mem_write) begin
      cap_s.kind  = KIND_STORE;
      cap_s.value = mem_data;
      cap_s.addr  = mem_addr;
    end else begin
      cap_s.kind = KIND_NOP;
    end
  end

  // FIFO write selection: live capture in RUN, held terminal record in TERM_PEND.
  always_comb begin
    push_s     = 1'b0;
    fifo_din_s = cap_s;
    case (state_r)
      ST_RUN:       push_s = space_s;
      ST_TERM_PEND: begin
        push_s     = space_s;
        fifo_din_s = pend_r;
      end
      default:      push_s = 1'b0;
    endcase
  end

  // Control FSM with counters, drop accounting and the pending terminal record.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_RUN;
      inst_cnt_r  <= '0;
      cycle_cnt_r <= '0;
      drop_cnt_r  <= '0;
      overflow_r  <= 1'b0;
      done_r      <= 1'b0;
      timeout_r   <= 1'b0;
      pend_r      <= '0;
    end else begin
      case (state_r)
        ST_RUN: begin
          cycle_cnt_r <= cycle_inc_s;
          inst_cnt_r  <= inst_inc_s;
          if (cap_s.kind == KIND_TIMEOUT) timeout_r <= 1'b1;
          if (is_terminal(cap_s.kind)) begin
            if (space_s) begin
              state_r <= ST_DONE;
              done_r  <= 1'b1;
            end else begin
              pend_r  <= cap_s;
              state_r <= ST_TERM_PEND;
            end
          end else if (!space_s) begin
            drop_cnt_r <= drop_inc_s;
            overflow_r <= 1'b1;
          end
        end
        ST_TERM_PEND: begin
          if (space_s) begin
            state_r <= ST_DONE;
            done_r  <= 1'b1;
          end
        end
        ST_DONE: begin
        end
        default: state_r <= ST_RUN;
      endcase
    end
  end

  trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .pop   (pop_s),
    .din   (fifo_din_s),
    .full  (full_s),
    .empty (empty_s),
    .head  (head_s)
  );

  assign rec_valid   = !empty_s;
  assign rec_kind    = empty_s ? 3'd0  : head_s.kind;
  assign rec_inum    = empty_s ? '0    : CNT_W'(head_s.inum);
  assign rec_pc      = empty_s ? 16'd0 : head_s.pc;
  assign rec_reg     = empty_s ? 4'd0  : head_s.dst_reg;
  assign rec_value   = empty_s ? 16'd0 : head_s.value;
  assign rec_addr    = empty_s ? 16'd0 : head_s.addr;
  assign inst_count  = inst_cnt_r;
  assign cycle_count = cycle_cnt_r;
  assign drop_count  = drop_cnt_r;
  assign overflow    = overflow_r;
  assign done        = done_r;
  assign timeout     = timeout_r;

endmodule

// File: tb/tb_retire_trace_unit.sv
// Scoreboard bench for retire_trace_unit: a reference model predicts every record and counter.
`timescale 1ns/1ps
module tb_retire_trace_unit;

  localparam int DEPTH = 8;
  localparam int CNT_W = 32;
  localparam int WD    = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] pc = 16'd0;
  logic        reg_write = 1'b0;
  logic [3:0]  write_reg = 4'd0;
  logic [15:0] write_data = 16'd0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [15:0] mem_addr = 16'd0;
  logic [15:0] mem_data = 16'd0;
  logic        halt = 1'b0;
  logic        rec_ready = 1'b0;
  logic        rec_valid;
  logic [2:0]  rec_kind;
  logic [CNT_W-1:0] rec_inum, inst_count, cycle_count, drop_count;
  logic [15:0] rec_pc, rec_value, rec_addr;
  logic [3:0]  rec_reg;
  logic        overflow, done, timeout;

  always #5 clk = ~clk;

  retire_trace_unit #(.DEPTH(DEPTH), .CNT_W(CNT_W), .WATCHDOG(WD)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .reg_write(reg_write), .write_reg(write_reg),
    .write_data(write_data), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_data(mem_data), .halt(halt),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_kind(rec_kind),
    .rec_inum(rec_inum), .rec_pc(rec_pc), .rec_reg(rec_reg), .rec_value(rec_value),
    .rec_addr(rec_addr), .inst_count(inst_count), .cycle_count(cycle_count),
    .drop_count(drop_count), .overflow(overflow), .done(done), .timeout(timeout)
  );

  typedef struct {
    logic [2:0]  kind;
    logic [31:0] inum;
    logic [15:0] pc;
    logic [3:0]  rg;
    logic [15:0] value;
    logic [15:0] addr;
  } exp_t;

  exp_t        sb_q[$];
  int          total = 0;
  int          bad = 0;
  int          m_state;
  int unsigned m_inst, m_cyc, m_drop, m_occ;
  logic        m_ovf, m_done, m_to;
  exp_t        m_pend;
  logic [2:0]  last_term_kind;
  logic [31:0] last_term_inum;
  logic        prev_hold = 1'b0;
  exp_t        prev_rec;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Output monitor: stability while stalled, scoreboard compare on each transfer.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold <= 1'b0;
    end else begin
      exp_t cur;
      cur.kind = rec_kind; cur.inum = rec_inum; cur.pc = rec_pc;
      cur.rg = rec_reg; cur.value = rec_value; cur.addr = rec_addr;
      if (prev_hold) begin
        check_eq("hold_valid", rec_valid, 1);
        check_eq("hold_kind", cur.kind, prev_rec.kind);
        check_eq("hold_inum", cur.inum, prev_rec.inum);
        check_eq("hold_value", cur.value, prev_rec.value);
      end
      prev_hold <= rec_valid && !rec_ready;
      prev_rec  <= cur;
      if (rec_valid && rec_ready) begin
        check_eq("sb_nonempty", sb_q.size() != 0, 1);
        if (sb_q.size() != 0) begin
          exp_t e;
          e = sb_q.pop_front();
          check_eq("rec_kind", cur.kind, e.kind);
          check_eq("rec_inum", cur.inum, e.inum);
          check_eq("rec_pc", cur.pc, e.pc);
          check_eq("rec_reg", cur.rg, e.rg);
          check_eq("rec_value", cur.value, e.value);
          check_eq("rec_addr", cur.addr, e.addr);
        end
        if (cur.kind == 3'd4 || cur.kind == 3'd5) begin
          last_term_kind <= cur.kind;
          last_term_inum <= cur.inum;
        end
      end
    end
  end

  // One clock of stimulus; the model then predicts what that edge did.
  task automatic step(input logic [15:0] p, input logic rw, input logic [3:0] wr,
                      input logic [15:0] wdat, input logic mr, input logic mw,
                      input logic [15:0] ma, input logic [15:0] md, input logic h,
                      input logic rdy);
    exp_t e;
    logic pop, term, space;
    pc = p; reg_write = rw; write_reg = wr; write_data = wdat; mem_read = mr;
    mem_write = mw; mem_addr = ma; mem_data = md; halt = h; rec_ready = rdy;
    @(posedge clk);
    #1;
    pop   = (m_occ > 0) && rdy;
    space = (m_occ < DEPTH) || pop;
    if (m_state == 0) begin
      m_cyc++;
      e.kind = 3'd3; e.inum = m_inst; e.pc = p; e.rg = 4'd0; e.value = 16'd0; e.addr = 16'd0;
      if (h) e.kind = 3'd4;
      else if (m_cyc == WD) e.kind = 3'd5;
      else if (rw && mr) begin e.kind = 3'd1; e.rg = wr; e.value = wdat; e.addr = ma; end
      else if (rw) begin e.kind = 3'd0; e.rg = wr; e.value = wdat; end
      else if (mw) begin e.kind = 3'd2; e.value = md; e.addr = ma; end
      m_inst++;
      term = (e.kind == 3'd4) || (e.kind == 3'd5);
      if (e.kind == 3'd5) m_to = 1'b1;
      if (space) begin
        sb_q.push_back(e);
        m_occ++;
        if (term) begin m_state = 2; m_done = 1'b1; end
      end else if (term) begin
        m_pend = e; m_state = 1;
      end else begin
        m_drop++; m_ovf = 1'b1;
      end
    end else if (m_state == 1 && space) begin
      sb_q.push_back(m_pend);
      m_occ++; m_state = 2; m_done = 1'b1;
    end
    if (pop) m_occ--;
  endtask

  task automatic do_nop(input logic [15:0] p, input logic rdy);
    step(p, 1'b0, 4'd0, 16'd0, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0, rdy);
  endtask

  task automatic do_reg(input logic [15:0] p, input logic [3:0] r, input logic [15:0] d, input logic rdy);
    step(p, 1'b1, r, d, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0, rdy);
  endtask

  task automatic do_halt(input logic [15:0] p, input logic rdy);
    step(p, 1'b0, 4'd0, 16'd0, 1'b0, 1'b0, 16'd0, 16'd0, 1'b1, rdy);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    rec_ready = 1'b0; halt = 1'b0; reg_write = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    sb_q.delete();
    m_state = 0; m_inst = 0; m_cyc = 0; m_drop = 0; m_occ = 0;
    m_ovf = 1'b0; m_done = 1'b0; m_to = 1'b0;
    last_term_kind = 3'd7; last_term_inum = '1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Runs with rec_ready high until the unit is done and the FIFO is empty.
  task automatic drain();
    for (int i = 0; i < 64 && (m_occ > 0 || m_state != 2); i++) do_nop(16'(16'h0100 + 2 * i), 1'b1);
    check_eq("sb_drained", sb_q.size(), 0);
  endtask

  task automatic check_counters(input string tag);
    check_eq({tag, "_inst"}, inst_count, m_inst);
    check_eq({tag, "_cycle"}, cycle_count, m_cyc);
    check_eq({tag, "_drop"}, drop_count, m_drop);
    check_eq({tag, "_ovf"}, overflow, m_ovf);
    check_eq({tag, "_done"}, done, m_done);
    check_eq({tag, "_tmo"}, timeout, m_to);
  endtask

  initial begin
    // Reset state
    rst_n = 1'b0;
    #3;
    check_eq("rst_valid", rec_valid, 0);
    check_eq("rst_fields", {rec_kind, rec_inum, rec_pc, rec_reg, rec_value, rec_addr}, 0);
    check_eq("rst_counts", {inst_count, cycle_count}, 0);
    check_eq("rst_flags", {drop_count, overflow, done, timeout}, 0);

    // Basic classification and latency
    apply_reset();
    do_reg(16'h0000, 4'd3, 16'h1234, 1'b1);
    check_eq("lat_valid", rec_valid, 1);
    check_eq("lat_kind", rec_kind, 3'd0);
    check_eq("lat_value", rec_value, 16'h1234);
    do_nop(16'h0002, 1'b1);
    check_eq("nop_kind", rec_kind, 3'd3);
    check_eq("nop_inum", rec_inum, 1);
    check_eq("nop_pc", rec_pc, 16'h0002);
    step(16'h0004, 1'b1, 4'd5, 16'hBEEF, 1'b1, 1'b0, 16'h0040, 16'd0, 1'b0, 1'b1);
    step(16'h0006, 1'b0, 4'd0, 16'd0, 1'b0, 1'b1, 16'h0010, 16'h00AA, 1'b0, 1'b1);
    do_halt(16'h0008, 1'b1);
    drain();
    check_eq("basic_term", last_term_kind, 3'd4);
    check_counters("basic");

    // Drops on a full FIFO, then simultaneous push/pop while full
    apply_reset();
    for (int i = 0; i < 10; i++) do_reg(16'(2 * i), 4'(i), 16'(16'h0A00 + i), 1'b0);
    check_eq("drop_count", drop_count, 2);
    check_eq("drop_ovf", overflow, 1);
    check_eq("drop_inst", inst_count, 10);
    check_eq("drop_valid", rec_valid, 1);
    do_nop(16'h0040, 1'b1);
    check_eq("drop_nodrop", drop_count, 2);
    drain();
    check_counters("drop");

    // Halt against a full FIFO waits in the pending register
    apply_reset();
    for (int i = 0; i < 8; i++) do_reg(16'(2 * i), 4'd1, 16'(i), 1'b0);
    do_halt(16'h0010, 1'b0);
    do_nop(16'h0012, 1'b0);
    do_nop(16'h0014, 1'b0);
    check_eq("pend_done", done, 0);
    check_eq("pend_inst", inst_count, 9);
    drain();
    check_eq("pend_term_kind", last_term_kind, 3'd4);
    check_eq("pend_term_inum", last_term_inum, 8);
    check_eq("pend_frozen_inst", inst_count, 9);
    check_eq("pend_frozen_cycle", cycle_count, 9);
    check_counters("pend");

    // Watchdog expiry
    apply_reset();
    drain();
    check_eq("wd_kind", last_term_kind, 3'd5);
    check_eq("wd_inum", last_term_inum, 19);
    check_eq("wd_cycle", cycle_count, 20);
    check_counters("wd");

    // Halt on the watchdog edge wins
    apply_reset();
    for (int i = 0; i < 19; i++) do_nop(16'(2 * i), 1'b1);
    do_halt(16'h0080, 1'b1);
    drain();
    check_eq("wdh_kind", last_term_kind, 3'd4);
    check_eq("wdh_inum", last_term_inum, 19);
    check_counters("wdh");

    // Asynchronous reset with records queued
    apply_reset();
    for (int i = 0; i < 4; i++) do_reg(16'(2 * i), 4'd2, 16'(i), 1'b0);
    check_eq("ar_pre_valid", rec_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("ar_valid", rec_valid, 0);
    check_eq("ar_inst", inst_count, 0);
    check_eq("ar_cycle", cycle_count, 0);
    apply_reset();
    do_reg(16'h0000, 4'd7, 16'h7777, 1'b1);
    do_halt(16'h0002, 1'b1);
    drain();
    check_counters("ar");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got=stuck expected=finish");
    $fatal(1);
  end

endmodule
